activ_loader784: RTL

ACTIV_LOADER784 -- requirements
Module: activ_loader784

---
 rtl/activ_loader784.sv | 95 +++++++++
 1 files changed

// File: rtl/activ_loader784.sv
// Purpose : collects one frame of 8-bit pixels into a packed Q8.24 activation vector
// Latency : activ_valid rises the cycle after the last pixel; pix_ready returns the cycle after a consume
// Backpres: pix_ready drops for the whole time a full frame waits for activ_ready; no bypass
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   pix_data/valid/sof pixel stream in; sof marks pixel index 0 (qualified by pix_valid)
//   pix_ready          high while filling
//   prev_activ         packed vector, pixel i at [i*W +: W], stable while activ_valid
//   activ_valid/ready  frame handshake towards the neuron layer
//   frame_count        frames consumed, modulo 2^16
module activ_loader784 #(
    parameter int N_IN = 784,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic [N_IN*W-1:0] prev_activ,
    output logic              activ_valid,
    input  logic              activ_ready,
    output logic [15:0]       frame_count
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [9:0] LAST = 10'(N_IN - 1);

    state_t            state_q, state_d;
    logic [9:0]        idx_q, idx_d;
    logic [9:0]        wr_slot;
    logic [N_IN*W-1:0] activ_q, activ_d;
    logic [15:0]       frame_count_q, frame_count_d;

    // A sof pixel always lands in slot 0, whatever the fill position was;
    // slots already written by the abandoned partial frame are left alone.
    assign wr_slot = pix_sof ? 10'd0 : idx_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        activ_d       = activ_q;
        frame_count_d = frame_count_q;
        case (state_q)
            FILL: begin
                // activ_ready is deliberately not looked at while filling
                if (pix_valid) begin
                    // pixel/256 in Q8.24: integer byte is zero, pixel sits in the top fraction byte
                    activ_d[int'(wr_slot)*W +: W] = W'({8'd0, pix_data, 16'd0});
                    if (wr_slot == LAST) begin
                        idx_d   = 10'd0;
                        state_d = FULL;
                    end else begin
                        idx_d = wr_slot + 10'd1;
                    end
                end
            end
            FULL: begin
                // pixels are ignored here, so the vector cannot move while valid
                if (activ_ready) begin
                    state_d       = FILL;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            idx_q         <= 10'd0;
            activ_q       <= '0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            activ_q       <= activ_d;
            frame_count_q <= frame_count_d;
        end
    end

    // All outputs come straight from registered state.
    assign pix_ready   = (state_q == FILL);
    assign activ_valid = (state_q == FULL);
    assign prev_activ  = activ_q;
    assign frame_count = frame_count_q;

endmodule
